// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store alignment unit.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  localparam logic [1:0] MEM_MODE_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD0,
    ST_RD1,
    ST_WR0,
    ST_WR1,
    ST_RESP
  } lsu_state_t;

  // Number of bytes touched by an access; the illegal encoding maps to 4
  // because callers reject it before the count matters.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_bytes = 3'd1;
      SIZE_HALF: size_bytes = 3'd2;
      default:   size_bytes = 3'd4;
    endcase
  endfunction

  // True when an access starting at byte offset off runs past the word.
  function automatic logic spans(input logic [1:0] off, input logic [1:0] size);
    spans = ({1'b0, off} + size_bytes(size)) > 3'd4;
  endfunction

endpackage

// File: rtl/lsu_align_unit_if.sv
// Request/response handshake plus word-wide data memory port of the LSU.
// Latency: none (wiring only).
// Backpressure: req_ready_o gates requests; responses and memory have none.
interface lsu_align_unit_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [1:0]  mem_mode_o;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_size_i,
           req_unsigned_i, mem_rdata_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
           mem_we_o, mem_addr_o, mem_wdata_o, mem_mode_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_size_i,
           req_unsigned_i, mem_rdata_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
           mem_we_o, mem_addr_o, mem_wdata_o, mem_mode_o
  );
endinterface

// File: rtl/lsu_lane_merge.sv
// Byte-lane store merge into a two-word window and load extract/extend from it.
// Latency: purely combinational.
// Backpressure: none.
module lsu_lane_merge
  import lsu_pkg::*;
(
  input  logic [63:0] rd_data,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  input  logic        is_unsigned,
  output logic [63:0] merged,
  output logic [31:0] load_data
);

  logic [2:0]  nbytes;
  logic [63:0] shifted;
  logic        sign_fill;

  assign nbytes  = size_bytes(size);
  assign shifted = rd_data >> {off, 3'b000};

  // Overlay the low store bytes onto lanes off..off+n-1, keep the rest.
  always_comb begin
    merged = rd_data;
    for (int k = 0; k < 4; k++) begin
      if (k < int'(nbytes)) begin
        merged[8*(int'(off)+k) +: 8] = wdata[8*k +: 8];
      end
    end
  end

  // Pick the low n bytes of the shifted window and extend them.
  always_comb begin
    sign_fill = 1'b0;
    case (size)
      SIZE_BYTE: begin
        sign_fill = ~is_unsigned & shifted[7];
        load_data = {{24{sign_fill}}, shifted[7:0]};
      end
      SIZE_HALF: begin
        sign_fill = ~is_unsigned & shifted[15];
        load_data = {{16{sign_fill}}, shifted[15:0]};
      end
      default: load_data = shifted[31:0];
    endcase
  end

endmodule

// File: rtl/lsu_align_unit.sv
// Load/store alignment unit: word-wide reads and read-modify-write stores; LSU_MISALIGNED_EN splits word-straddling accesses.
// Latency: 1 (error), 2 (load / full word store), 3 (narrow store, spanning load), 5 (spanning store).
// Backpressure: req_ready_o only in IDLE; one request in flight; response is a pulse with no backpressure.
module lsu_align_unit
  import lsu_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  lsu_align_unit_if.slave bus
);

  lsu_state_t  state, state_nxt;
  logic        r_we, r_uns, r_err;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_wdata, buf0;
  logic        accept, in_err, in_full_word, span_act;
  logic [31:0] a0;
  logic [63:0] rd64, merged;
  logic [31:0] load_data;

  assign accept       = (state == ST_IDLE) && bus.req_valid_i;
  assign in_full_word = bus.req_we_i && (bus.req_size_i == SIZE_WORD) &&
                        (bus.req_addr_i[1:0] == 2'b00);
  assign a0           = {r_addr[31:2], 2'b00};
  assign bus.mem_mode_o = MEM_MODE_WORD;

`ifdef LSU_MISALIGNED_EN
  logic [31:0] buf1;
  logic [31:0] a1;
  assign a1       = a0 + 32'd4;
  assign span_act = spans(r_addr[1:0], r_size);
  assign rd64     = {buf1, buf0};
  assign in_err   = bus.req_size_i == SIZE_ILLEGAL;
`else
  logic unused_hi;
  assign span_act  = 1'b0;
  assign rd64      = {32'h0, buf0};
  assign in_err    = (bus.req_size_i == SIZE_ILLEGAL) ||
                     spans(bus.req_addr_i[1:0], bus.req_size_i);
  assign unused_hi = ^merged[63:32];
`endif

  lsu_lane_merge u_merge (
    .rd_data     (rd64),
    .off         (r_addr[1:0]),
    .size        (r_size),
    .wdata       (r_wdata),
    .is_unsigned (r_uns),
    .merged      (merged),
    .load_data   (load_data)
  );

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Capture the request on the accept edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_err   <= 1'b0;
      r_size  <= SIZE_BYTE;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
    end else if (accept) begin
      r_we    <= bus.req_we_i;
      r_uns   <= bus.req_unsigned_i;
      r_err   <= in_err;
      r_size  <= bus.req_size_i;
      r_addr  <= bus.req_addr_i;
      r_wdata <= bus.req_wdata_i;
    end
  end

  // Read buffers load the asynchronous memory data at the end of each read cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      buf0 <= 32'h0;
`ifdef LSU_MISALIGNED_EN
      buf1 <= 32'h0;
`endif
    end else begin
      if (state == ST_RD0) buf0 <= bus.mem_rdata_i;
`ifdef LSU_MISALIGNED_EN
      if (state == ST_RD1) buf1 <= bus.mem_rdata_i;
`endif
    end
  end

  // Next-state and per-state outputs; everything idles at zero.
  always_comb begin
    state_nxt        = state;
    bus.req_ready_o  = 1'b0;
    bus.resp_valid_o = 1'b0;
    bus.resp_rdata_o = 32'h0;
    bus.resp_err_o   = 1'b0;
    bus.mem_we_o     = 1'b0;
    bus.mem_addr_o   = 32'h0;
    bus.mem_wdata_o  = 32'h0;
    case (state)
      ST_IDLE: begin
        bus.req_ready_o = 1'b1;
        if (accept) begin
          if (in_err)            state_nxt = ST_RESP;
          else if (in_full_word) state_nxt = ST_WR0;
          else                   state_nxt = ST_RD0;
        end
      end
      ST_RD0: begin
        bus.mem_addr_o = a0;
        if (span_act)  state_nxt = ST_RD1;
        else if (r_we) state_nxt = ST_WR0;
        else           state_nxt = ST_RESP;
      end
`ifdef LSU_MISALIGNED_EN
      ST_RD1: begin
        bus.mem_addr_o = a1;
        state_nxt      = r_we ? ST_WR0 : ST_RESP;
      end
`endif
      ST_WR0: begin
        bus.mem_we_o    = 1'b1;
        bus.mem_addr_o  = a0;
        bus.mem_wdata_o = merged[31:0];
        state_nxt       = span_act ? ST_WR1 : ST_RESP;
      end
`ifdef LSU_MISALIGNED_EN
      ST_WR1: begin
        bus.mem_we_o    = 1'b1;
        bus.mem_addr_o  = a1;
        bus.mem_wdata_o = merged[63:32];
        state_nxt       = ST_RESP;
      end
`endif
      ST_RESP: begin
        bus.resp_valid_o = 1'b1;
        bus.resp_err_o   = r_err;
        bus.resp_rdata_o = (r_err || r_we) ? 32'h0 : load_data;
        state_nxt        = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_align_unit.sv
// Bench for lsu_align_unit: directed cases plus random requests against a byte-array memory model.
// Latency: n/a.
// Backpressure: n/a.
module tb_lsu_align_unit;
  import lsu_pkg::*;

`ifdef LSU_MISALIGNED_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic clk, rst;
  int   vectors, miscompares;

  lsu_align_unit_if bus ();
  lsu_align_unit dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT-facing memory and the reference image the model updates.
  logic [7:0] mem     [0:255];
  logic [7:0] ref_mem [0:255];
  logic       pl_en;
  logic [7:0] pl_addr, pl_dat, ma;

  assign ma = {bus.mem_addr_o[7:2], 2'b00};

  // Asynchronous word read of the addressed word.
  always_comb bus.mem_rdata_i = {mem[ma+8'd3], mem[ma+8'd2], mem[ma+8'd1], mem[ma]};

  // Word write from the DUT, or a single-byte preload from the bench.
  always @(posedge clk) begin
    if (bus.mem_we_o) begin
      mem[ma]       <= bus.mem_wdata_o[7:0];
      mem[ma+8'd1]  <= bus.mem_wdata_o[15:8];
      mem[ma+8'd2]  <= bus.mem_wdata_o[23:16];
      mem[ma+8'd3]  <= bus.mem_wdata_o[31:24];
    end else if (pl_en) begin
      mem[pl_addr] <= pl_dat;
    end
  end

  logic [31:0] last_rdata;
  int          last_lat;
  logic        last_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_addr = a; pl_dat = d; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic check_image();
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_image", 64'(bad), 64'd0);
  endtask

  // One request end to end; hold keeps valid high with a different request while busy.
  task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns, input bit hold);
    int n, off, lat, exp_lat;
    bit span, err;
    logic [31:0] a0, a1, exp_rdata;
    logic [32:0] exp_acc[$];
    logic [32:0] got_acc[$];
    n = (size == SIZE_BYTE) ? 1 : (size == SIZE_HALF) ? 2 : 4;
    off = int'(addr[1:0]);
    span = (off + n) > 4;
    a0 = addr & 32'hFFFF_FFFC;
    a1 = a0 + 32'd4;
    err = (size == SIZE_ILLEGAL) || (span && !MIS);
    exp_rdata = 32'h0;
    exp_lat = 1;
    if (!err && !we) begin
      exp_acc.push_back({1'b0, a0});
      if (span) exp_acc.push_back({1'b0, a1});
      exp_lat = span ? 3 : 2;
      for (int k = 0; k < n; k++) exp_rdata |= 32'(ref_mem[8'(addr + 32'(k))]) << (8 * k);
      if (!uns && n < 4 && exp_rdata[8*n-1]) exp_rdata |= ~((32'd1 << (8 * n)) - 32'd1);
    end else if (!err) begin
      if (size == SIZE_WORD && off == 0) begin
        exp_acc.push_back({1'b1, a0});
        exp_lat = 2;
      end else begin
        exp_acc.push_back({1'b0, a0});
        if (span) exp_acc.push_back({1'b0, a1});
        exp_acc.push_back({1'b1, a0});
        if (span) exp_acc.push_back({1'b1, a1});
        exp_lat = span ? 5 : 3;
      end
      for (int k = 0; k < n; k++) ref_mem[8'(addr + 32'(k))] = wdata[8*k +: 8];
    end

    bus.req_we_i = we; bus.req_addr_i = addr; bus.req_wdata_i = wdata;
    bus.req_size_i = size; bus.req_unsigned_i = uns; bus.req_valid_i = 1'b1;
    @(posedge clk); #1;
    if (hold) begin
      bus.req_we_i = 1'b1; bus.req_addr_i = addr ^ 32'h40;
      bus.req_size_i = SIZE_WORD; bus.req_wdata_i = ~wdata;
    end else begin
      bus.req_valid_i = 1'b0;
    end
    lat = 1;
    while (!bus.resp_valid_o && lat < 20) begin
      got_acc.push_back({bus.mem_we_o, bus.mem_addr_o});
      if (hold) chk("busy_ready", 64'(bus.req_ready_o), 64'd0);
      @(posedge clk); #1;
      lat++;
    end
    bus.req_valid_i = 1'b0;
    chk("resp_seen", 64'(bus.resp_valid_o), 64'd1);
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("resp_err", 64'(bus.resp_err_o), 64'(err));
    chk("resp_rdata", 64'(bus.resp_rdata_o), 64'(exp_rdata));
    chk("acc_count", 64'(got_acc.size()), 64'(exp_acc.size()));
    for (int i = 0; i < exp_acc.size() && i < got_acc.size(); i++)
      chk("acc_we_addr", 64'(got_acc[i]), 64'(exp_acc[i]));
    check_image();
    last_rdata = bus.resp_rdata_o; last_lat = lat; last_err = bus.resp_err_o;
    @(posedge clk); #1;
    chk("resp_pulse_ready", 64'({bus.resp_valid_o, bus.req_ready_o}), 64'd1);
  endtask

  // Start a request, reset it after `extra` further edges, and check nothing completes.
  task automatic abort_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] size, input int extra, input logic [31:0] exp_addr);
    bus.req_we_i = we; bus.req_addr_i = addr; bus.req_wdata_i = wdata;
    bus.req_size_i = size; bus.req_unsigned_i = 1'b0; bus.req_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    repeat (extra) begin @(posedge clk); #1; end
    chk("abort_pre_addr", 64'(bus.mem_addr_o), 64'(exp_addr));
    chk("abort_pre_we", 64'(bus.mem_we_o), 64'd0);
    rst = 1'b1; #1;
    chk("abort_we", 64'(bus.mem_we_o), 64'd0);
    chk("abort_resp", 64'(bus.resp_valid_o), 64'd0);
    chk("abort_ready", 64'(bus.req_ready_o), 64'd1);
    chk("abort_addr", 64'(bus.mem_addr_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("after_abort_quiet", 64'({bus.resp_valid_o, bus.mem_we_o}), 64'd0);
    end
    check_image();
  endtask

  initial begin
    logic        r_we, r_uns;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    vectors = 0; miscompares = 0;
    rst = 1'b1; pl_en = 1'b0; pl_addr = 8'h0; pl_dat = 8'h0;
    bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_addr_i = 32'h0;
    bus.req_wdata_i = 32'h0; bus.req_size_i = SIZE_BYTE; bus.req_unsigned_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(bus.req_ready_o), 64'd1);
    chk("rst_resp_valid", 64'(bus.resp_valid_o), 64'd0);
    chk("rst_rdata", 64'(bus.resp_rdata_o), 64'd0);
    chk("rst_err", 64'(bus.resp_err_o), 64'd0);
    chk("rst_mem_we", 64'(bus.mem_we_o), 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr_o), 64'd0);
    chk("rst_mem_wdata", 64'(bus.mem_wdata_o), 64'd0);
    chk("rst_mem_mode", 64'(bus.mem_mode_o), 64'd2);
    rst = 1'b0;

    for (int i = 0; i < 256; i++) preload(8'(i), 8'($urandom));

    // Byte loads from a word holding 44 83 22 11.
    preload(8'h4, 8'h44); preload(8'h5, 8'h83); preload(8'h6, 8'h22); preload(8'h7, 8'h11);
    run_req(1'b0, 32'h5, 32'h0, SIZE_BYTE, 1'b0, 1'b0);
    chk("lb_signed_val", 64'(last_rdata), 64'hFFFF_FF83);
    chk("lb_signed_lat", 64'(last_lat), 64'd2);
    run_req(1'b0, 32'h5, 32'h0, SIZE_BYTE, 1'b1, 1'b0);
    chk("lbu_val", 64'(last_rdata), 64'h0000_0083);
    chk("lbu_lat", 64'(last_lat), 64'd2);

    // Narrow store merges into the surrounding word.
    preload(8'h4, 8'h44); preload(8'h5, 8'h33); preload(8'h6, 8'h22); preload(8'h7, 8'h11);
    run_req(1'b1, 32'h6, 32'h0000_00AB, SIZE_BYTE, 1'b0, 1'b0);
    chk("sb_word", 64'({mem[7], mem[6], mem[5], mem[4]}), 64'h11AB_3344);
    chk("sb_lat", 64'(last_lat), 64'd3);

    run_req(1'b1, 32'h8, 32'hDEAD_BEEF, SIZE_WORD, 1'b0, 1'b0);
    chk("sw_word", 64'({mem[11], mem[10], mem[9], mem[8]}), 64'hDEAD_BEEF);
    chk("sw_lat", 64'(last_lat), 64'd2);

    // Word load straddling words 0x0 and 0x4.
    for (int i = 0; i < 8; i++) preload(8'(i), 8'(8'h11 * i));
    run_req(1'b0, 32'h2, 32'h0, SIZE_WORD, 1'b0, 1'b0);
`ifdef LSU_MISALIGNED_EN
    chk("lw_span_val", 64'(last_rdata), 64'h5544_3322);
    chk("lw_span_lat", 64'(last_lat), 64'd3);
`else
    chk("lw_span_err", 64'(last_err), 64'd1);
    chk("lw_span_lat", 64'(last_lat), 64'd1);
`endif

    run_req(1'b1, 32'h10, 32'h1234_5678, SIZE_ILLEGAL, 1'b0, 1'b0);
    chk("illegal_err", 64'(last_err), 64'd1);
    chk("illegal_lat", 64'(last_lat), 64'd1);

    run_req(1'b0, 32'h20, 32'h0, SIZE_WORD, 1'b0, 1'b1);

`ifdef LSU_MISALIGNED_EN
    run_req(1'b1, 32'h3, 32'h0000_BEEF, SIZE_HALF, 1'b0, 1'b0);
    chk("sh_span_b3", 64'(mem[3]), 64'hEF);
    chk("sh_span_b4", 64'(mem[4]), 64'hBE);
    chk("sh_span_lat", 64'(last_lat), 64'd5);
    abort_req(1'b1, 32'h3, 32'h0000_1234, SIZE_HALF, 1, 32'h4);
`else
    abort_req(1'b1, 32'h6, 32'h0000_00CD, SIZE_BYTE, 0, 32'h4);
`endif

    // Random traffic, including the top of the address space where A1 wraps.
    for (int i = 0; i < 300; i++) begin
      r_we   = 1'($urandom_range(0, 1));
      r_uns  = 1'($urandom_range(0, 1));
      r_size = ($urandom_range(0, 9) == 9) ? SIZE_ILLEGAL : 2'($urandom_range(0, 2));
      r_addr = ($urandom_range(0, 7) == 0) ? {24'hFF_FFFF, 8'($urandom)}
                                           : 32'($urandom_range(0, 255));
      run_req(r_we, r_addr, $urandom, r_size, r_uns, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
